// File: rtl/mem_stage_if.sv
// Handshake and bus bundle around the MEM stage: EX->MEM payload, MEM->WB
// payload, data-SRAM response and the bypass/stall bus back to ID.
interface mem_stage_if;
  logic        es_to_ms_valid;
  logic [74:0] es_to_ms_bus;
  logic        ms_allow_in;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        ws_allow_in;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [38:0] ms_to_ds_bus;

  // MEM stage side
  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allow_in,
           data_sram_data_ok, data_sram_rdata,
    output ms_allow_in, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
  );

  // Surrounding pipeline / environment side
  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allow_in,
           data_sram_data_ok, data_sram_rdata,
    input  ms_allow_in, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
  );
endinterface

// File: rtl/mem_stage.sv
// LoongArch MEM stage: holds one instruction, waits for the data-SRAM
// response owed by a load/store, aligns/extends load data, forwards the
// result to ID and hands it to WB via valid/allow_in.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  typedef struct packed {
    logic        res_from_mem;
    logic        mem_we;
    logic [2:0]  ld_type;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] alu_result;
  } es_payload_t;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100
  } ld_type_e;

  es_payload_t ms_payload;
  logic        ms_valid;
  logic        resp_got;
  logic [31:0] resp_data;

  logic        need_resp;
  logic        ms_ready_go;
  logic        handoff;
  logic [31:0] ld_src;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] aligned_load;
  logic [31:0] final_result;

  assign need_resp   = ms_payload.res_from_mem | ms_payload.mem_we;
  assign ms_ready_go = !need_resp || resp_got || bus.data_sram_data_ok;
  assign handoff     = bus.ms_to_ws_valid && bus.ws_allow_in;

  assign bus.ms_to_ws_valid = ms_valid && ms_ready_go;
  assign bus.ms_allow_in    = !ms_valid || (ms_ready_go && bus.ws_allow_in);

  // Stage occupancy: refilled from EX whenever the stage can accept.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ms_valid <= 1'b0;
    end else if (bus.ms_allow_in) begin
      ms_valid <= bus.es_to_ms_valid;
    end
  end

  // Instruction payload capture on accept.
  // NOTE: the payload is deliberately not reset; every consumer qualifies it
  // with ms_valid, so reset would only add fan-out on a wide register.
  always_ff @(posedge clk) begin
    if (bus.es_to_ms_valid && bus.ms_allow_in) begin
      ms_payload <= bus.es_to_ms_bus;
    end
  end

  // Response-received flag: survives a WB stall, cleared at handoff.
  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_got <= 1'b0;
    end else if (handoff) begin
      resp_got <= 1'b0;
    end else if (ms_valid && need_resp && bus.data_sram_data_ok) begin
      resp_got <= 1'b1;
    end
  end

  // Response data buffer, written alongside resp_got being set.
  always_ff @(posedge clk) begin
    if (ms_valid && need_resp && bus.data_sram_data_ok && !handoff) begin
      resp_data <= bus.data_sram_rdata;
    end
  end

  assign ld_src = resp_got ? resp_data : bus.data_sram_rdata;

  // Byte/half selection and sign/zero extension of the load data.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    ld_byte      = ld_src[7:0];
    ld_half      = ld_src[15:0];
    aligned_load = ld_src;
    case (ms_payload.alu_result[1:0])
      2'd0:    ld_byte = ld_src[7:0];
      2'd1:    ld_byte = ld_src[15:8];
      2'd2:    ld_byte = ld_src[23:16];
      default: ld_byte = ld_src[31:24];
    endcase
    if (ms_payload.alu_result[1]) ld_half = ld_src[31:16];
    case (ms_payload.ld_type)
      LD_W:    aligned_load = ld_src;
      LD_B:    aligned_load = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   aligned_load = {24'd0, ld_byte};
      LD_H:    aligned_load = {{16{ld_half[15]}}, ld_half};
      LD_HU:   aligned_load = {16'd0, ld_half};
      default: aligned_load = ld_src;
    endcase
  end

  assign final_result = ms_payload.res_from_mem ? aligned_load
                                                : ms_payload.alu_result;

  assign bus.ms_to_ws_bus = {ms_payload.rf_we & ms_valid,
                             ms_valid ? ms_payload.dest : 5'd0,
                             ms_payload.pc,
                             final_result};

  // fwd_blk tells ID the load result is not yet usable for bypass.
  assign bus.ms_to_ds_bus = {ms_valid & ms_payload.rf_we,
                             ms_valid & ms_payload.res_from_mem & !ms_ready_go,
                             ms_payload.dest,
                             final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset state, ALU pass-through, load
// alignment table streamed back-to-back, delayed response, WB stall with
// buffered response, and reset during a pending load.
module tb_mem_stage;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_stage_if ifc ();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ws_result;
  logic [4:0]  ws_dest;
  logic        ws_rf_we;
  logic        fwd_we;
  logic        fwd_blk;
  assign ws_result = ifc.ms_to_ws_bus[31:0];
  assign ws_dest   = ifc.ms_to_ws_bus[68:64];
  assign ws_rf_we  = ifc.ms_to_ws_bus[69];
  assign fwd_we    = ifc.ms_to_ds_bus[38];
  assign fwd_blk   = ifc.ms_to_ds_bus[37];

  task automatic check(input string tag, input logic [69:0] obs,
                       input logic [69:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs driven afterwards are stable
  // well before the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [74:0] mk(input logic rfm, input logic we,
                                     input logic [2:0] lt, input logic rfwe,
                                     input logic [4:0] d, input logic [31:0] pc,
                                     input logic [31:0] alu);
    return {rfm, we, lt, rfwe, d, pc, alu};
  endfunction

  typedef struct {
    logic [2:0]  lt;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab [7];

  initial begin
    ld_tab[0] = '{3'b001, 32'h0000_1003, 32'h80FF_0011, 32'hFFFF_FF80}; // ld.b
    ld_tab[1] = '{3'b100, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001}; // ld.hu
    ld_tab[2] = '{3'b011, 32'h0000_0001, 32'h1234_F600, 32'h0000_00F6}; // ld.bu
    ld_tab[3] = '{3'b010, 32'h0000_0000, 32'h1234_8001, 32'hFFFF_8001}; // ld.h
    ld_tab[4] = '{3'b000, 32'h0000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF}; // ld.w
    ld_tab[5] = '{3'b111, 32'h0000_0003, 32'hCAFE_F00D, 32'hCAFE_F00D}; // other
    ld_tab[6] = '{3'b001, 32'h0000_0000, 32'h0000_007F, 32'h0000_007F}; // ld.b +

    rst = 1'b0;
    ifc.es_to_ms_valid    = 1'b0;
    ifc.es_to_ms_bus      = '0;
    ifc.ws_allow_in       = 1'b1;
    ifc.data_sram_data_ok = 1'b0;
    ifc.data_sram_rdata   = '0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_allow_in",  70'(ifc.ms_allow_in),    70'(1));
    check("rst_to_ws_vld", 70'(ifc.ms_to_ws_valid), 70'(0));
    check("rst_fwd_we",    70'(fwd_we),             70'(0));
    check("rst_fwd_blk",   70'(fwd_blk),            70'(0));
    check("rst_ws_rf_we",  70'(ws_rf_we),           70'(0));

    // ALU instruction: one-cycle latency
    ifc.es_to_ms_valid = 1'b1;
    ifc.es_to_ms_bus   = mk(1'b0, 1'b0, 3'b000, 1'b1, 5'd5, 32'h1c00_0010, 32'h1234);
    #1;
    check("alu_accept", 70'(ifc.ms_allow_in), 70'(1));
    tick();
    ifc.es_to_ms_valid = 1'b0;
    #1;
    check("alu_to_ws_vld", 70'(ifc.ms_to_ws_valid), 70'(1));
    check("alu_ws_bus", ifc.ms_to_ws_bus,
          {1'b1, 5'd5, 32'h1c00_0010, 32'h0000_1234});
    check("alu_fwd_we",  70'(fwd_we),  70'(1));
    check("alu_fwd_blk", 70'(fwd_blk), 70'(0));
    tick();
    #1;
    check("alu_left", 70'(ifc.ms_to_ws_valid), 70'(0));

    // Loads streamed back-to-back, each answered in its first MEM cycle
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) begin
        ifc.es_to_ms_valid = 1'b1;
        ifc.es_to_ms_bus   = mk(1'b1, 1'b0, ld_tab[i].lt, 1'b1, 5'(i + 1),
                                32'h1c00_0100 + 32'(i * 4), ld_tab[i].addr);
      end else begin
        ifc.es_to_ms_valid = 1'b0;
      end
      if (i > 0) begin
        ifc.data_sram_data_ok = 1'b1;
        ifc.data_sram_rdata   = ld_tab[i-1].rdata;
      end
      #1;
      if (i > 0) begin
        check($sformatf("ld%0d_to_ws_vld", i - 1), 70'(ifc.ms_to_ws_valid), 70'(1));
        check($sformatf("ld%0d_result", i - 1), 70'(ws_result), 70'(ld_tab[i-1].exp));
        check($sformatf("ld%0d_dest", i - 1), 70'(ws_dest), 70'(i));
        check($sformatf("ld%0d_fwd_blk", i - 1), 70'(fwd_blk), 70'(0));
      end
      check($sformatf("ld%0d_allow_in", i), 70'(ifc.ms_allow_in), 70'(1));
      tick();
    end
    ifc.data_sram_data_ok = 1'b0;
    #1;
    check("ld_stream_drained", 70'(ifc.ms_to_ws_valid), 70'(0));

    // Load whose response arrives 3 cycles late; an ALU op waits in EX
    ifc.es_to_ms_valid = 1'b1;
    ifc.es_to_ms_bus   = mk(1'b1, 1'b0, 3'b000, 1'b1, 5'd9, 32'h1c00_0200, 32'h0000_0040);
    tick();
    ifc.es_to_ms_bus   = mk(1'b0, 1'b0, 3'b000, 1'b1, 5'd10, 32'h1c00_0204, 32'h0000_0055);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("dly_fwd_blk_c%0d", k),  70'(fwd_blk),             70'(1));
      check($sformatf("dly_allow_in_c%0d", k), 70'(ifc.ms_allow_in),    70'(0));
      check($sformatf("dly_to_ws_c%0d", k),    70'(ifc.ms_to_ws_valid), 70'(0));
      tick();
    end
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = 32'h0BAD_F00D;
    #1;
    check("dly_to_ws_vld", 70'(ifc.ms_to_ws_valid), 70'(1));
    check("dly_result",    70'(ws_result),          70'(32'h0BAD_F00D));
    check("dly_fwd_blk",   70'(fwd_blk),            70'(0));
    check("dly_allow_in",  70'(ifc.ms_allow_in),    70'(1));
    tick();
    ifc.data_sram_data_ok = 1'b0;
    ifc.es_to_ms_valid    = 1'b0;
    #1;
    check("dly_next_alu_vld",  70'(ifc.ms_to_ws_valid), 70'(1));
    check("dly_next_alu_res",  70'(ws_result),          70'(32'h55));
    check("dly_next_alu_dest", 70'(ws_dest),            70'(10));
    tick();

    // Store answered while WB stalls for 2 cycles
    ifc.ws_allow_in    = 1'b0;
    ifc.es_to_ms_valid = 1'b1;
    ifc.es_to_ms_bus   = mk(1'b0, 1'b1, 3'b000, 1'b0, 5'd0, 32'h1c00_0300, 32'h0000_0100);
    tick();
    ifc.es_to_ms_valid    = 1'b0;
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = 32'hA5A5_A5A5;
    #1;
    check("st_to_ws_vld_c0", 70'(ifc.ms_to_ws_valid), 70'(1));
    check("st_allow_in_c0",  70'(ifc.ms_allow_in),    70'(0));
    check("st_ws_rf_we",     70'(ws_rf_we),           70'(0));
    tick();
    ifc.data_sram_data_ok = 1'b0;
    #1;
    check("st_resp_got",     70'(dut.resp_got),       70'(1));
    check("st_to_ws_vld_c1", 70'(ifc.ms_to_ws_valid), 70'(1));
    check("st_result",       70'(ws_result),          70'(32'h100));
    ifc.ws_allow_in = 1'b1;
    #1;
    check("st_handoff_offer", 70'(ifc.ms_to_ws_valid), 70'(1));
    tick();
    check("st_single_handoff", 70'(ifc.ms_to_ws_valid), 70'(0));
    check("st_resp_got_clr",   70'(dut.resp_got),       70'(0));

    // Load answered during a WB stall: buffered data must be used
    ifc.ws_allow_in    = 1'b0;
    ifc.es_to_ms_valid = 1'b1;
    ifc.es_to_ms_bus   = mk(1'b1, 1'b0, 3'b001, 1'b1, 5'd12, 32'h1c00_0400, 32'h0000_0003);
    tick();
    ifc.es_to_ms_valid    = 1'b0;
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = 32'h80FF_0011;
    tick();
    ifc.data_sram_data_ok = 1'b0;
    ifc.data_sram_rdata   = 32'h1111_1111;
    #1;
    check("buf_ld_result",  70'(ws_result), 70'(32'hFFFF_FF80));
    check("buf_ld_fwd_blk", 70'(fwd_blk),   70'(0));
    ifc.ws_allow_in = 1'b1;
    tick();
    check("buf_ld_left",  70'(ifc.ms_to_ws_valid), 70'(0));
    check("buf_resp_clr", 70'(dut.resp_got),       70'(0));

    // Reset while a load waits, then a stray response
    ifc.es_to_ms_valid = 1'b1;
    ifc.es_to_ms_bus   = mk(1'b1, 1'b0, 3'b000, 1'b1, 5'd13, 32'h1c00_0500, 32'h0000_0008);
    tick();
    ifc.es_to_ms_valid = 1'b0;
    #1;
    check("rstw_pending_blk", 70'(fwd_blk), 70'(1));
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rstw_ms_valid",  70'(dut.ms_valid),       70'(0));
    check("rstw_resp_got",  70'(dut.resp_got),       70'(0));
    check("rstw_allow_in",  70'(ifc.ms_allow_in),    70'(1));
    check("rstw_to_ws_vld", 70'(ifc.ms_to_ws_valid), 70'(0));
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = 32'h7777_7777;
    #1;
    check("stray_to_ws_vld", 70'(ifc.ms_to_ws_valid), 70'(0));
    tick();
    ifc.data_sram_data_ok = 1'b0;
    #1;
    check("stray_resp_got", 70'(dut.resp_got),       70'(0));
    check("stray_ms_valid", 70'(dut.ms_valid),       70'(0));
    check("stray_fwd_we",   70'(fwd_we),             70'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
